// File: rtl/font_rom_arbiter_pkg.sv
// Shared widths, colour codes and pipeline record for the font ROM arbiter.
// No logic; latency/backpressure not applicable.
package font_rom_arbiter_pkg;

    localparam int CHAR_W  = 7;
    localparam int ROW_W   = 4;
    localparam int BIT_W   = 3;
    localparam int ADDR_W  = CHAR_W + ROW_W;
    localparam int IDX_W   = 3;
    localparam int FCNT_W  = 6;
    localparam int ROM_LAT = 1;

    typedef logic [2:0] rgb_t;

    localparam rgb_t RGB_BLACK = 3'b000;
    localparam rgb_t RGB_GREEN = 3'b010;
    localparam rgb_t RGB_WHITE = 3'b111;

    // Per-pixel state carried alongside the ROM access.
    typedef struct packed {
        logic              video;
        logic [BIT_W-1:0]  bit_sel;
        rgb_t              color;
    } s1_t;

    function automatic logic [ADDR_W-1:0] font_addr(input logic [CHAR_W-1:0] ch,
                                                    input logic [ROW_W-1:0]  row);
        return {ch, row};
    endfunction

endpackage

// File: rtl/font_rom_arbiter_if.sv
// Pixel-side requester bus plus font ROM port of the arbiter.
// Latency/backpressure defined by the arbiter: 2 cycles, never stalls.
interface font_rom_arbiter_if #(parameter int N_REQ = 8);
    import font_rom_arbiter_pkg::*;

    logic                    video_on;
    logic                    frame_tick;
    logic [N_REQ-1:0]        req_on;
    logic [CHAR_W*N_REQ-1:0] req_char;
    logic [ROW_W*N_REQ-1:0]  req_row;
    logic [BIT_W*N_REQ-1:0]  req_bit;
    logic [3*N_REQ-1:0]      req_color;
    logic [N_REQ-1:0]        blink_mask;
    rgb_t                    bg_color;
    logic [ADDR_W-1:0]       rom_addr;
    logic [7:0]              rom_data;
    logic                    grant_valid;
    logic [IDX_W-1:0]        grant_idx;
    rgb_t                    graph_rgb;

    modport master (
        output video_on, frame_tick, req_on, req_char, req_row, req_bit,
               req_color, blink_mask, bg_color, rom_data,
        input  rom_addr, grant_valid, grant_idx, graph_rgb
    );

    modport slave (
        input  video_on, frame_tick, req_on, req_char, req_row, req_bit,
               req_color, blink_mask, bg_color, rom_data,
        output rom_addr, grant_valid, grant_idx, graph_rgb
    );

endinterface

// File: rtl/font_rom_arbiter_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins.
// Purely combinational; no backpressure.
module prio_enc
    import font_rom_arbiter_pkg::*;
#(
    parameter int N_REQ = 8
) (
    input  logic [N_REQ-1:0] req,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        vld = 1'b0;
        idx = '0;
        // Walk downward so the lowest index overwrites any higher one.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                vld = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one external font ROM among N_REQ text regions and produces the pixel colour.
// Latency: 2 cycles pixel-in to graph_rgb; no backpressure, one pixel per cycle.
module font_rom_arbiter
    import font_rom_arbiter_pkg::*;
#(
    parameter int N_REQ     = 8,
    parameter int BLINK_DIV = 30
) (
    input  logic              CLK,
    input  logic              RESET,
    font_rom_arbiter_if.slave bus
);

    logic [FCNT_W-1:0] frame_cnt;
    logic              blink_phase;
    logic [N_REQ-1:0]  eligible;
    logic              win_vld;
    logic [IDX_W-1:0]  win_idx;
    logic [CHAR_W-1:0] win_char;
    logic [ROW_W-1:0]  win_row;
    logic [BIT_W-1:0]  win_bit;
    rgb_t              win_color;
    s1_t               s1_d;
    s1_t               s1_q;

    // A blinking requester drops out during the hidden phase so the next one wins.
    assign eligible = bus.req_on & ~(bus.blink_mask & {N_REQ{blink_phase}});

    prio_enc #(.N_REQ(N_REQ)) u_prio_enc (
        .req (eligible),
        .vld (win_vld),
        .idx (win_idx)
    );

    always_comb begin
        win_char  = '0;
        win_row   = '0;
        win_bit   = '0;
        win_color = RGB_BLACK;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_char  = bus.req_char[i*CHAR_W +: CHAR_W];
                win_row   = bus.req_row[i*ROW_W +: ROW_W];
                win_bit   = bus.req_bit[i*BIT_W +: BIT_W];
                win_color = bus.req_color[i*3 +: 3];
            end
        end
    end

    assign bus.rom_addr = win_vld ? font_addr(win_char, win_row) : '0;
    assign s1_d         = '{video: bus.video_on, bit_sel: win_bit, color: win_color};

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (bus.frame_tick) begin
            if (frame_cnt == FCNT_W'(BLINK_DIV - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            bus.grant_valid <= 1'b0;
            bus.grant_idx   <= '0;
            s1_q            <= '0;
            bus.graph_rgb   <= RGB_BLACK;
        end else begin
            bus.grant_valid <= win_vld;
            if (win_vld) begin
                bus.grant_idx <= win_idx;
            end
            s1_q <= s1_d;
            // rom_data now holds the word addressed by the pixel in s1_q; MSB is column 0.
            if (!s1_q.video) begin
                bus.graph_rgb <= RGB_BLACK;
            end else if (bus.grant_valid && bus.rom_data[3'd7 - s1_q.bit_sel]) begin
                bus.graph_rgb <= s1_q.color;
            end else begin
                bus.graph_rgb <= bus.bg_color;
            end
        end
    end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed and randomized checks of font_rom_arbiter against a pixel-level reference model.
module tb_font_rom_arbiter;

    localparam int N         = 8;
    localparam int BLINK_DIV = 30;

    typedef struct {
        bit          vld;
        int          win;
        logic [10:0] addr;
        logic [2:0]  bitn;
        logic [2:0]  col;
        bit          video;
    } pix_t;

    logic CLK;
    logic RESET;
    font_rom_arbiter_if #(.N_REQ(N)) bus ();

    font_rom_arbiter #(.N_REQ(N), .BLINK_DIV(BLINK_DIV)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    logic [7:0] font [0:2047];
    int   tests = 0;
    int   fails = 0;
    int   m_cnt = 0;
    bit   m_phase = 0;
    int   m_gidx = 0;
    pix_t prv;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // External synchronous font ROM: one cycle of read latency.
    always @(posedge CLK) bus.rom_data <= font[bus.rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [6:0] ch, input logic [3:0] row,
                           input logic [2:0] bitn, input logic [2:0] col);
        bus.req_char[7*i +: 7]  = ch;
        bus.req_row[4*i +: 4]   = row;
        bus.req_bit[3*i +: 3]   = bitn;
        bus.req_color[3*i +: 3] = col;
    endtask

    // Called 1 time unit after a rising edge with the next pixel's inputs applied.
    task automatic cycle();
        pix_t       cur;
        logic [2:0] exp_rgb;
        bit         exp_gv;
        #3;
        cur = '{default: 0};
        cur.win = -1;
        for (int i = 0; i < N; i++)
            if (cur.win < 0 && bus.req_on[i] && !(bus.blink_mask[i] && m_phase)) cur.win = i;
        cur.vld   = (cur.win >= 0);
        cur.video = bus.video_on;
        if (cur.vld) begin
            cur.addr = {bus.req_char[7*cur.win +: 7], bus.req_row[4*cur.win +: 4]};
            cur.bitn = bus.req_bit[3*cur.win +: 3];
            cur.col  = bus.req_color[3*cur.win +: 3];
        end
        check("rom_addr", 32'(bus.rom_addr), 32'(cur.addr));
        if (!prv.video)                                       exp_rgb = 3'b000;
        else if (prv.vld && font[prv.addr][7 - int'(prv.bitn)]) exp_rgb = prv.col;
        else                                                  exp_rgb = bus.bg_color;
        @(posedge CLK);
        #1;
        if (!RESET) begin
            m_cnt   = 0;
            m_phase = 0;
            m_gidx  = 0;
            exp_gv  = 0;
            exp_rgb = 3'b000;
            prv     = '{default: 0};
        end else begin
            exp_gv = cur.vld;
            if (cur.vld) m_gidx = cur.win;
            if (bus.frame_tick) begin
                if (m_cnt == BLINK_DIV - 1) begin
                    m_cnt   = 0;
                    m_phase = !m_phase;
                end else begin
                    m_cnt++;
                end
            end
            prv = cur;
        end
        check("grant_valid", 32'(bus.grant_valid), 32'(exp_gv));
        check("grant_idx", 32'(bus.grant_idx), 32'(m_gidx));
        check("graph_rgb", 32'(bus.graph_rgb), 32'(exp_rgb));
    endtask

    task automatic clear_inputs();
        bus.video_on   = 1'b0;
        bus.frame_tick = 1'b0;
        bus.req_on     = '0;
        bus.req_char   = '0;
        bus.req_row    = '0;
        bus.req_bit    = '0;
        bus.req_color  = '0;
        bus.blink_mask = '0;
        bus.bg_color   = 3'b000;
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) font[a] = 8'($urandom);
        font[11'h463] = 8'h20;
        font[11'h015] = 8'hFF;
        prv = '{default: 0};
        clear_inputs();

        // Reset state.
        RESET = 1'b0;
        cycle();
        cycle();
        check("rst_frame_cnt", 32'(dut.frame_cnt), 0);
        check("rst_blink_phase", 32'(dut.blink_phase), 0);
        RESET = 1'b1;

        // Requester 1 wins over 2; glyph 0x46 row 3 column 2.
        bus.video_on = 1'b1;
        bus.bg_color = 3'b001;
        bus.req_on   = 8'b0000_0110;
        set_req(1, 7'h46, 4'd3, 3'd2, 3'b010);
        set_req(2, 7'h12, 4'd9, 3'd5, 3'b111);
        #1 check("dir_rom_addr", 32'(bus.rom_addr), 32'h463);
        cycle();
        check("dir_grant_idx", 32'(bus.grant_idx), 1);
        bus.req_on = '0;
        cycle();
        check("dir_graph_rgb", 32'(bus.graph_rgb), 32'(3'b010));

        // No requester: background, then blanking.
        cycle();
        cycle();
        check("idle_bg", 32'(bus.graph_rgb), 32'(3'b001));
        check("idle_gv", 32'(bus.grant_valid), 0);
        check("idle_idx_hold", 32'(bus.grant_idx), 1);
        bus.video_on = 1'b0;
        cycle();
        cycle();
        check("blank_rgb", 32'(bus.graph_rgb), 0);

        // Alternate top and bottom priority requesters every pixel.
        bus.video_on = 1'b1;
        set_req(7, 7'h01, 4'd5, 3'd0, 3'b100);
        set_req(0, 7'h01, 4'd5, 3'd7, 3'b011);
        for (int k = 0; k < 6; k++) begin
            bus.req_on = (k % 2 == 0) ? 8'h80 : 8'h01;
            cycle();
            check("alt_idx", 32'(bus.grant_idx), (k % 2 == 0) ? 7 : 0);
        end

        // Randomized pixels.
        for (int k = 0; k < 300; k++) begin
            bus.video_on   = ($urandom_range(0, 3) != 0);
            bus.frame_tick = ($urandom_range(0, 3) == 0);
            bus.req_on     = 8'($urandom);
            bus.blink_mask = 8'($urandom);
            bus.req_char   = 56'({$urandom, $urandom});
            bus.req_row    = 32'($urandom);
            bus.req_bit    = 24'($urandom);
            bus.req_color  = 24'($urandom);
            bus.bg_color   = 3'($urandom);
            cycle();
        end
        check("rand_frame_cnt", 32'(dut.frame_cnt), 32'(m_cnt));
        check("rand_blink_phase", 32'(dut.blink_phase), 32'(m_phase));

        // Blink: requester 0 hides after BLINK_DIV ticks, returns after BLINK_DIV more.
        clear_inputs();
        RESET = 1'b0;
        cycle();
        RESET = 1'b1;
        bus.video_on   = 1'b1;
        bus.req_on     = 8'h03;
        bus.blink_mask = 8'h01;
        set_req(0, 7'h01, 4'd5, 3'd1, 3'b111);
        set_req(1, 7'h01, 4'd5, 3'd2, 3'b010);
        for (int p = 0; p < 2; p++) begin
            for (int t = 0; t < BLINK_DIV; t++) begin
                bus.frame_tick = 1'b1;
                cycle();
                bus.frame_tick = 1'b0;
                cycle();
            end
            check("blink_phase", 32'(dut.blink_phase), (p == 0) ? 1 : 0);
            check("blink_winner", 32'(bus.grant_idx), (p == 0) ? 1 : 0);
        end

        // Reset during the third of three granted pixels.
        bus.frame_tick = 1'b1;
        cycle();
        cycle();
        bus.frame_tick = 1'b0;
        cycle();
        RESET = 1'b0;
        cycle();
        check("midrst_rgb", 32'(bus.graph_rgb), 0);
        check("midrst_gv", 32'(bus.grant_valid), 0);
        check("midrst_cnt", 32'(dut.frame_cnt), 0);
        RESET = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/font_rom_arbiter.md
FONT_ROM_ARBITER -- requirements
Module: font_rom_arbiter

Interface
REQ-001 Parameter N_REQ, default 8: number of text-region requesters sharing one font ROM (2..8).
REQ-002 Parameter BLINK_DIV, default 30: frame_tick pulses per blink half-period (2..63).
REQ-003 CLK  input  1  system/pixel clock; all logic on its rising edge.
REQ-004 RESET  input  1  reset, synchronous and active-low.
REQ-005 video_on  input  1  VGA active-area flag for the current pixel.
REQ-006 frame_tick  input  1  one-cycle pulse per frame start.
REQ-007 req_on  input  N_REQ  region i covers the current pixel.
REQ-008 req_char  input  7*N_REQ  ASCII/glyph code of requester i, slice [7i+6:7i].
REQ-009 req_row  input  4*N_REQ  glyph row of requester i.
REQ-010 req_bit  input  3*N_REQ  glyph column of requester i.
REQ-011 req_color  input  3*N_REQ  RGB foreground of requester i.
REQ-012 blink_mask  input  N_REQ  requester i blinks when set.
REQ-013 bg_color  input  3  RGB for active pixels with no lit glyph bit.
REQ-014 rom_addr  output  11  font ROM address {char,row}.
REQ-015 rom_data  input  8  font ROM word, valid one cycle after rom_addr.
REQ-016 grant_valid  output  1  registered: a requester won the previous cycle.
REQ-017 grant_idx  output  3  registered index of that winner.
REQ-018 graph_rgb  output  3  registered pixel colour to the VGA sync block.

Function
REQ-019 Arbitration SHALL be fixed priority: lowest index i with req_on[i]=1 and not (blink_mask[i] and blink_phase=1) wins.
REQ-020 rom_addr SHALL combinationally equal {req_char[i],req_row[i]} of the winner, and 11'h000 when no winner.
REQ-021 Stage 1 SHALL register grant_valid, grant_idx, the winner's bit and colour, and video_on.
REQ-022 Stage 2 SHALL set graph_rgb: 3'b000 if delayed video_on=0; else winner colour if grant_valid and rom_data[7-bit]=1; else bg_color.
REQ-023 Latency SHALL be exactly 2 cycles from pixel inputs to graph_rgb, with no stalls and one pixel per cycle.
REQ-024 A frame counter (6 bits) SHALL increment on frame_tick; on frame_tick at count BLINK_DIV-1 it SHALL wrap to 0 and toggle blink_phase.
REQ-025 Without frame_tick, counter and blink_phase SHALL hold.
REQ-026 A blinked-out requester SHALL lose arbitration so the next eligible lower-priority requester wins the pixel.
REQ-027 When no requester is eligible, grant_valid SHALL be 0 and grant_idx SHALL hold its previous value.
REQ-028 Unused requester indices ≥ N_REQ SHALL never be granted.

Reset
REQ-029 With RESET=0 at a clock edge: graph_rgb=3'b000, grant_valid=0, grant_idx=0, frame counter=0, blink_phase=0 (visible), all pipeline registers cleared.
REQ-030 Reset mid-frame SHALL take effect on the next edge; the first valid graph_rgb SHALL appear 2 cycles after RESET returns to 1.

Structure
REQ-031 Shared package SHALL hold: font address widths (CHAR_W=7, ROW_W=4, BIT_W=3), RGB codes (BLACK 000, GREEN 010, WHITE 111), and the ROM latency constant (1).
REQ-032 The priority selection SHALL be one sub-module, prio_enc (N_REQ-bit request vector -> valid + 3-bit index).
REQ-033 The font ROM SHALL remain external; this block owns only its address port.

Verification
REQ-034 req_on=8'b0000_0110, req_char[1]=7'h46, row 3, bit 2, colour 010, video_on=1 -> rom_addr=11'h463 in the same cycle; grant_idx=1 one cycle later; graph_rgb=010 two cycles later if rom_data[5]=1, else bg_color.
REQ-035 req_on=0, video_on=1, bg_color=3'b001 -> grant_valid=0, graph_rgb=001 after 2 cycles; with video_on=0 -> graph_rgb=000.
REQ-036 blink_mask=8'h01, req_on=8'h03, BLINK_DIV=30, 30 frame_ticks -> blink_phase=1 and requester 1 wins; 30 more -> requester 0 wins again.
REQ-037 RESET=0 asserted during the third of 3 consecutive granted pixels -> next edge graph_rgb=000, grant_valid=0, counter=0.
REQ-038 Alternating req_on 8'h80 / 8'h01 each cycle -> grant_idx sequence 7,0,7,0 delayed one cycle, with graph_rgb colours matching per pixel at 2-cycle latency.
